// File: rtl/cp0_regs_pkg.sv
// Shared CP0 definitions: architectural register numbers, exception vector,
// and the encodings of the control unit's next-PC and mfc0 selects.
package cp0_regs_pkg;

  localparam int unsigned XLEN = 32;

  // Architectural CP0 register numbers (rd field of mtc0/mfc0).
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [XLEN-1:0] EXC_BASE = 32'h0000_0008;

  typedef enum logic [1:0] {
    SELPC_NPC     = 2'b00,
    SELPC_EPC     = 2'b01,
    SELPC_EXC     = 2'b10,
    SELPC_NPC_ALT = 2'b11
  } selpc_e;

  typedef enum logic [1:0] {
    MFC0_ZERO   = 2'b00,
    MFC0_STATUS = 2'b01,
    MFC0_CAUSE  = 2'b10,
    MFC0_EPC    = 2'b11
  } mfc0_sel_e;

  // Maps the compact mfc0 select onto the architectural register number;
  // 0 stands for "no CP0 register" and reads as zero.
  function automatic logic [4:0] mfc0_reg_num(input mfc0_sel_e sel);
    logic [4:0] num;
    num = 5'd0;
    case (sel)
      MFC0_STATUS: num = CP0_STATUS;
      MFC0_CAUSE:  num = CP0_CAUSE;
      MFC0_EPC:    num = CP0_EPC;
      default:     num = 5'd0;
    endcase
    return num;
  endfunction

endpackage

// File: rtl/cp0_intr_latch.sv
// Interrupt request edge detector and pending latch. A rising edge on the
// level request sets pending; inta clears it unless a new edge arrives too.
module cp0_intr_latch
  import cp0_regs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic intr_req,
  input  logic inta,
  output logic intr
);

  logic intr_req_d;
  logic pending;
  logic rise;

  assign rise = intr_req & ~intr_req_d;

  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples pre-edge values; reset is synchronous and checked first.
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_req_d <= 1'b0;
      pending    <= 1'b0;
    end else begin
      intr_req_d <= intr_req;
      // A fresh edge wins over the acknowledge so a new request is not lost.
      pending    <= rise | (pending & ~inta);
    end
  end

  assign intr = pending;

endmodule

// File: rtl/cp0_regs.sv
// CP0 Status/Cause/EPC register file with exception/eret sequencing,
// mfc0 read mux and next-PC select.
module cp0_regs
  import cp0_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        intr_req,
  input  logic        inta,
  input  logic        exc,
  input  logic        eret,
  input  logic        mtc0,
  input  logic        wsta,
  input  logic        wcau,
  input  logic        wepc,
  input  logic [31:0] cause_in,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic [1:0]  selpc,
  input  logic [1:0]  mfc0,
  output logic [31:0] sta,
  output logic [31:0] cau,
  output logic [31:0] epc,
  output logic        intr,
  output logic [31:0] c0_rdata,
  output logic [31:0] pc_next
);

  cp0_intr_latch u_intr_latch (
    .clk      (clk),
    .rst      (rst),
    .intr_req (intr_req),
    .inta     (inta),
    .intr     (intr)
  );

  // Status acts as a 4-bit-per-level mask stack: exceptions push, eret pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sta <= '0;
      cau <= '0;
      epc <= '0;
    end else begin
      if (exc)
        sta <= sta << 4;
      else if (eret)
        sta <= sta >> 4;
      else if (mtc0 && wsta)
        sta <= wdata;

      if (exc)
        cau <= cause_in;
      else if (mtc0 && wcau)
        cau <= wdata;

      // Interrupts resume after the current instruction; faults retry it.
      if (exc && inta)
        epc <= npc;
      else if (exc)
        epc <= pc;
      else if (mtc0 && wepc)
        epc <= wdata;
    end
  end

  logic [4:0] rd_num;
  assign rd_num = mfc0_reg_num(mfc0_sel_e'(mfc0));

  // NOTE: every combinational output gets a default first so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    c0_rdata = '0;
    case (rd_num)
      CP0_STATUS: c0_rdata = sta;
      CP0_CAUSE:  c0_rdata = cau;
      CP0_EPC:    c0_rdata = epc;
      default:    c0_rdata = '0;
    endcase
  end

  always_comb begin
    pc_next = npc;
    case (selpc_e'(selpc))
      SELPC_NPC:     pc_next = npc;
      SELPC_EPC:     pc_next = epc;
      SELPC_EXC:     pc_next = EXC_BASE;
      SELPC_NPC_ALT: pc_next = npc;
      default:       pc_next = npc;
    endcase
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed bench for cp0_regs: register sequencing, muxes, priority,
// reset override and the interrupt pending latch.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        intr_req, inta, exc, eret, mtc0, wsta, wcau, wepc;
  logic [31:0] cause_in, wdata, pc, npc;
  logic [1:0]  selpc, mfc0;
  logic [31:0] sta, cau, epc, c0_rdata, pc_next;
  logic        intr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_regs dut (
    .clk      (clk),
    .rst      (rst),
    .intr_req (intr_req),
    .inta     (inta),
    .exc      (exc),
    .eret     (eret),
    .mtc0     (mtc0),
    .wsta     (wsta),
    .wcau     (wcau),
    .wepc     (wepc),
    .cause_in (cause_in),
    .wdata    (wdata),
    .pc       (pc),
    .npc      (npc),
    .selpc    (selpc),
    .mfc0     (mfc0),
    .sta      (sta),
    .cau      (cau),
    .epc      (epc),
    .intr     (intr),
    .c0_rdata (c0_rdata),
    .pc_next  (pc_next)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; inta = 1'b0; exc = 1'b0; eret = 1'b0; mtc0 = 1'b0;
    wsta = 1'b0; wcau = 1'b0; wepc = 1'b0; cause_in = '0; wdata = '0;
    selpc = 2'b00; mfc0 = 2'b00;
  endtask

  task automatic write_sta(input logic [31:0] v);
    mtc0 = 1'b1; wsta = 1'b1; wdata = v;
    step();
    idle();
  endtask

  initial begin
    idle();
    intr_req = 1'b0; pc = 32'h0000_0100; npc = 32'h0000_0104;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_sta", sta, 32'h0);
    check("rst_cau", cau, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_intr", {31'b0, intr}, 32'h0);
    mfc0 = 2'b00; #1;
    check("rd_zero", c0_rdata, 32'h0);

    // mtc0 Status, with no bypass before the edge
    mtc0 = 1'b1; wsta = 1'b1; wdata = 32'h0000_000F; mfc0 = 2'b01; #1;
    check("rd_no_bypass", c0_rdata, 32'h0);
    step();
    idle(); mfc0 = 2'b01; #1;
    check("mtc0_sta", sta, 32'h0000_000F);
    check("rd_sta", c0_rdata, 32'h0000_000F);

    // interrupt exception: EPC gets npc, Status pushes
    exc = 1'b1; inta = 1'b1; cause_in = 32'h0; selpc = 2'b10; #1;
    check("pcn_exc", pc_next, 32'h0000_0008);
    step();
    idle(); #1;
    check("exc_sta", sta, 32'h0000_00F0);
    check("exc_epc", epc, 32'h0000_0104);
    check("exc_cau", cau, 32'h0);

    // eret: pc_next from EPC same cycle, Status pops next cycle
    eret = 1'b1; selpc = 2'b01; #1;
    check("pcn_eret", pc_next, 32'h0000_0104);
    step();
    idle(); mfc0 = 2'b11; #1;
    check("eret_sta", sta, 32'h0000_000F);
    check("rd_epc", c0_rdata, 32'h0000_0104);

    // faulting exception: EPC gets pc
    pc = 32'h0000_0200; exc = 1'b1; cause_in = 32'h0000_000C;
    step();
    idle(); mfc0 = 2'b10; #1;
    check("ovf_epc", epc, 32'h0000_0200);
    check("ovf_cau", cau, 32'h0000_000C);
    check("ovf_sta", sta, 32'h0000_00F0);
    check("rd_cau", c0_rdata, 32'h0000_000C);

    // selpc 00 / 11 both give npc
    selpc = 2'b00; #1;
    check("pcn_00", pc_next, 32'h0000_0104);
    selpc = 2'b11; #1;
    check("pcn_11", pc_next, 32'h0000_0104);
    idle();

    // mtc0 Cause/EPC; enables without mtc0 do nothing
    mtc0 = 1'b1; wcau = 1'b1; wepc = 1'b1; wdata = 32'h0000_0300;
    step();
    idle();
    check("mtc0_cau", cau, 32'h0000_0300);
    check("mtc0_epc", epc, 32'h0000_0300);
    wcau = 1'b1; wepc = 1'b1; wsta = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    idle();
    check("hold_cau", cau, 32'h0000_0300);
    check("hold_epc", epc, 32'h0000_0300);
    check("hold_sta", sta, 32'h0000_00F0);

    // shifts discard bits, no wrap
    write_sta(32'hF000_0001);
    exc = 1'b1; inta = 1'b1;
    step();
    idle();
    check("shl_discard", sta, 32'h0000_0010);
    write_sta(32'h0000_001F);
    eret = 1'b1;
    step();
    idle();
    check("shr_discard", sta, 32'h0000_0001);

    // priority: exc over eret over mtc0
    write_sta(32'h0000_0003);
    pc = 32'h0000_0400;
    exc = 1'b1; eret = 1'b1; mtc0 = 1'b1; wsta = 1'b1; wcau = 1'b1; wepc = 1'b1;
    wdata = 32'h0000_AAAA; cause_in = 32'h0000_0008;
    step();
    idle();
    check("pri_sta", sta, 32'h0000_0030);
    check("pri_epc", epc, 32'h0000_0400);
    check("pri_cau", cau, 32'h0000_0008);
    eret = 1'b1; mtc0 = 1'b1; wsta = 1'b1; wdata = 32'h0000_0077;
    step();
    idle();
    check("pri_eret", sta, 32'h0000_0003);

    // interrupt latch
    intr_req = 1'b1;
    step();
    check("irq_rise", {31'b0, intr}, 32'h1);
    step();
    check("irq_hold", {31'b0, intr}, 32'h1);
    inta = 1'b1;
    step();
    inta = 1'b0;
    check("irq_ack", {31'b0, intr}, 32'h0);
    step();
    check("irq_held0", {31'b0, intr}, 32'h0);
    step();
    check("irq_held1", {31'b0, intr}, 32'h0);
    intr_req = 1'b0;
    step();
    check("irq_low", {31'b0, intr}, 32'h0);
    intr_req = 1'b1; inta = 1'b1;
    step();
    inta = 1'b0;
    check("irq_rise_ack", {31'b0, intr}, 32'h1);
    step();
    check("irq_keep", {31'b0, intr}, 32'h1);

    // reset overrides everything; pending is set at this point
    write_sta(32'h1234_5678);
    rst = 1'b1; exc = 1'b1; eret = 1'b1; mtc0 = 1'b1; wsta = 1'b1;
    wcau = 1'b1; wepc = 1'b1; wdata = 32'hFFFF_FFFF; cause_in = 32'hFFFF_FFFF;
    step();
    check("rst_ovr_sta", sta, 32'h0);
    check("rst_ovr_cau", cau, 32'h0);
    check("rst_ovr_epc", epc, 32'h0);
    check("rst_ovr_intr", {31'b0, intr}, 32'h0);
    idle();
    // edge history was cleared, so the still-high request is a new edge
    step();
    check("irq_after_rst", {31'b0, intr}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
